// File: rtl/logic_arb_pkg.sv
// Shared types for logic_unit_arbiter: opcodes, FSM encoding and the bitwise op helper.
package logic_arb_pkg;

  localparam int unsigned LOGIC_W = 32;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_RSV6 = 3'd6;
  localparam logic [2:0] OP_RSV7 = 3'd7;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [LOGIC_W-1:0] data;
    logic               err;
  } op_result_t;

  // Bitwise gate blocks; reserved opcodes yield zero data with err set.
  function automatic op_result_t logic_op(input logic [2:0] op,
                                          input logic [LOGIC_W-1:0] a,
                                          input logic [LOGIC_W-1:0] b);
    op_result_t r;
    r.data = '0;
    r.err  = 1'b0;
    case (op)
      OP_AND:  r.data = a & b;
      OP_NAND: r.data = ~(a & b);
      OP_OR:   r.data = a | b;
      OP_NOR:  r.data = ~(a | b);
      OP_XOR:  r.data = a ^ b;
      OP_NOT:  r.data = ~a;
      default: r.err  = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first valid requester at or above ptr, else wraps to the lowest valid.
module rr_priority_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any_valid
);

  logic [NREQ-1:0] hi_valid;
  logic [NREQ-1:0] pick;

  always_comb begin
    hi_valid  = '0;
    pick      = '0;
    grant     = '0;
    grant_id  = '0;
    any_valid = |valid;
    for (int i = 0; i < int'(NREQ); i++) begin
      hi_valid[i] = valid[i] && (i >= int'(ptr));
    end
    pick = (|hi_valid) ? hi_valid : valid;
    // Descending scan so the lowest set bit of pick wins.
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        grant_id = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit bitwise logic unit behind a single result register.
// Optional feature macro: LOGIC_ARB_ZERO_FLAG_EN (registered rsp_zero flag).
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [3*NREQ-1:0]       req_op,
  input  logic [LOGIC_W*NREQ-1:0] req_a,
  input  logic [LOGIC_W*NREQ-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [LOGIC_W-1:0]      rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_err,
  output logic                    rsp_zero
);

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     ptr_next;
  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     grant_id;
  logic               any_valid;
  logic               can_accept;
  logic               accept;
  logic [2:0]         sel_op;
  logic [LOGIC_W-1:0] sel_a;
  logic [LOGIC_W-1:0] sel_b;
  op_result_t         res;

  rr_priority_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .any_valid (any_valid)
  );

  // Operand mux into the shared gate blocks.
  assign sel_op   = req_op[int'(grant_id)*3 +: 3];
  assign sel_a    = req_a[int'(grant_id)*int'(LOGIC_W) +: LOGIC_W];
  assign sel_b    = req_b[int'(grant_id)*int'(LOGIC_W) +: LOGIC_W];
  assign res      = logic_op(sel_op, sel_a, sel_b);
  assign ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

  // Next-state and handshake decode.
  always_comb begin
    state_d    = state_q;
    can_accept = (state_q == ST_EMPTY) || rsp_ready;
    accept     = can_accept && any_valid && !reset;
    req_ready  = accept ? grant : '0;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      ptr_q    <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q    <= ptr_next;
        rsp_data <= res.data;
        rsp_id   <= grant_id;
        rsp_err  <= res.err;
      end
    end
  end

  assign rsp_valid = (state_q == ST_FULL);

`ifdef LOGIC_ARB_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_zero <= 1'b0;
    end else if (accept) begin
      rsp_zero <= ~(|res.data);
    end
  end
`else
  assign rsp_zero = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed scoreboard bench for logic_unit_arbiter (4 requesters).
module tb_logic_unit_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0]    data;
    logic [IDW-1:0] id;
    logic           err;
    logic           zero;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [3*NREQ-1:0]    req_op;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_err;
  logic                 rsp_zero;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  logic [2:0]  t_op[NREQ];
  logic [31:0] t_a[NREQ];
  logic [31:0] t_b[NREQ];

  logic_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .rsp_zero  (rsp_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return ~(a & b);
      3'd2: return a | b;
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~a;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    t_op[i] = op;
    t_a[i]  = a;
    t_b[i]  = b;
    req_op[3*i +: 3]   = op;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
  endtask

  // One clock: check handshake at negedge, retire/queue results, then step past posedge.
  task automatic cycle(input logic [NREQ-1:0] exp_ready, input logic exp_valid);
    exp_t e;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (rsp_valid && rsp_ready) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (exp_ready[i]) begin
        e.data = model(t_op[i], t_a[i], t_b[i]);
        e.id   = IDW'(i);
        e.err  = (t_op[i] >= 3'd6);
        e.zero = ZERO_EN && (e.data == 32'h0);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_data"}, rsp_data, 32'h0);
    check({tag, "_id"}, 32'(rsp_id), 32'h0);
    check({tag, "_err"}, 32'(rsp_err), 32'h0);
    check({tag, "_zero"}, 32'(rsp_zero), 32'h0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, 32'h0, 32'h0);

    // Reset state, with all requesters asserting valid.
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = '0;

    // Single AND from requester 0.
    set_req(0, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00);
    req_valid = 4'b0001;
    cycle(4'b0001, 1'b0);
    req_valid = 4'b0000;
    cycle(4'b0000, 1'b1);

    // Lone requester 3 with ptr at 1, leaving ptr at 0.
    set_req(3, 3'd5, 32'h0F0F1234, 32'hDEADBEEF);
    req_valid = 4'b1000;
    cycle(4'b1000, 1'b0);

    // All four valid: grants rotate 0,1,2,3,0 with no bubbles.
    set_req(0, 3'd2, $urandom, $urandom);
    set_req(1, 3'd1, $urandom, $urandom);
    set_req(2, 3'd3, $urandom, $urandom);
    set_req(3, 3'd5, $urandom, $urandom);
    req_valid = 4'b1111;
    cycle(4'b0001, 1'b1);
    cycle(4'b0010, 1'b1);
    cycle(4'b0100, 1'b1);
    cycle(4'b1000, 1'b1);
    cycle(4'b0001, 1'b1);

    // Backpressure: result held, requester 1 waits.
    set_req(1, 3'd4, 32'hA5A5A5A5, 32'h0F0F0F0F);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0000, 1'b1);
      check("hold_data", rsp_data, sb[0].data);
      check("hold_id", 32'(rsp_id), 32'(sb[0].id));
    end
    rsp_ready = 1'b1;
    cycle(4'b0010, 1'b1);

    // XOR of equal operands, then reserved op 7.
    set_req(2, 3'd4, 32'h12345678, 32'h12345678);
    req_valid = 4'b0100;
    cycle(4'b0100, 1'b1);
    set_req(3, 3'd7, 32'hFFFFFFFF, 32'h12345678);
    req_valid = 4'b1000;
    cycle(4'b1000, 1'b1);
    req_valid = 4'b0000;
    cycle(4'b0000, 1'b1);

    // Wrap after grant 3: req0 beats req2, then ptr=1 lets req2 win.
    set_req(0, 3'd0, 32'hCAFEF00D, 32'h00FF00FF);
    set_req(2, 3'd3, 32'h00000000, 32'h00000001);
    req_valid = 4'b0101;
    cycle(4'b0001, 1'b0);
    cycle(4'b0100, 1'b1);
    req_valid = 4'b0000;
    cycle(4'b0000, 1'b1);

    // Reset while FULL with req2 still pending.
    set_req(2, 3'd6, 32'h11111111, 32'h22222222);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    cycle(4'b0100, 1'b0);
    reset = 1'b1;
    cycle(4'b0000, 1'b1);
    sb.delete();
    reset     = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");
    @(posedge clk); #1;
    set_req(0, 3'd1, 32'h00000000, 32'h00000000);
    set_req(2, 3'd2, 32'h80000000, 32'h00000001);
    req_valid = 4'b0101;
    cycle(4'b0001, 1'b0);
    req_valid = 4'b0000;
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
